// File: rtl/veer_types.sv
// Shared types for the POSU request path: one-hot opcode and the
// per-entry request packet held by the request queue.
package veer_types;

    typedef struct packed {
        logic add;
        logic sub;
        logic mul;
        logic div;
    } posu_op_t;

    typedef struct packed {
        posu_op_t   op;
        logic [4:0] rd;
    } posu_req_pkt_t;

endpackage

// File: rtl/posu_onehot_chk.sv
// Combinational legality check: a POSU opcode is legal only when
// exactly one of its four bits is set.
module posu_onehot_chk
    import veer_types::*;
(
    input  posu_op_t op,
    output logic     legal
);

    logic [3:0] bits;

    assign bits  = op;
    // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
    assign legal = (bits != 4'd0) && ((bits & (bits - 4'd1)) == 4'd0);

endmodule

// File: rtl/posu_req_queue.sv
// Dual-issue request buffer in front of the POSU: admits up to two legal
// requests per cycle in program order and issues one head entry per cycle.
module posu_req_queue
    import veer_types::*;
#(
    parameter int DEPTH = 4,
    parameter int NBITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       i0_valid,
    input  posu_op_t                   i0_op,
    input  logic [4:0]                 i0_rd,
    input  logic [NBITS-1:0]           i0_a,
    input  logic [NBITS-1:0]           i0_b,
    input  logic                       i1_valid,
    input  posu_op_t                   i1_op,
    input  logic [4:0]                 i1_rd,
    input  logic [NBITS-1:0]           i1_a,
    input  logic [NBITS-1:0]           i1_b,
    output logic [$clog2(DEPTH+1)-1:0] free_cnt,
    output logic                       out_valid,
    output posu_op_t                   out_op,
    output logic [4:0]                 out_rd,
    output logic [NBITS-1:0]           out_a,
    output logic [NBITS-1:0]           out_b,
    input  logic                       out_ready,
    output logic                       err_ovf,
    output logic                       err_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    posu_req_pkt_t    pkt_q [DEPTH];
    logic [NBITS-1:0] a_q   [DEPTH];
    logic [NBITS-1:0] b_q   [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [CW-1:0] count_q;
    logic [CW-1:0] space;
    logic [CW-1:0] n_adm;

    logic i0_legal;
    logic i1_legal;
    logic i0_ok;
    logic i1_ok;
    logic adm0;
    logic adm1;
    logic deq;
    logic ovf_hit;
    logic illegal_hit;

    posu_onehot_chk u_chk_i0 (.op(i0_op), .legal(i0_legal));
    posu_onehot_chk u_chk_i1 (.op(i1_op), .legal(i1_legal));

    assign out_valid = (count_q != '0);
    assign out_op    = pkt_q[rd_ptr].op;
    assign out_rd    = pkt_q[rd_ptr].rd;
    assign out_a     = a_q[rd_ptr];
    assign out_b     = b_q[rd_ptr];
    assign free_cnt  = CW'(DEPTH) - count_q;

    assign deq   = out_valid & out_ready;
    assign space = CW'(DEPTH) - count_q + CW'(deq);

    // Oldest-first admission: i1 only gets whatever slot i0 left behind.
    assign i0_ok       = i0_valid & i0_legal;
    assign i1_ok       = i1_valid & i1_legal;
    assign adm0        = i0_ok && (space != '0);
    assign adm1        = i1_ok && (space > (adm0 ? CW'(1) : CW'(0)));
    assign n_adm       = CW'(adm0) + CW'(adm1);
    assign wr_ptr_next = wr_ptr + PW'(adm0);

    assign ovf_hit     = (i0_ok & ~adm0) | (i1_ok & ~adm1);
    assign illegal_hit = (i0_valid & ~i0_legal) | (i1_valid & ~i1_legal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            err_ovf     <= 1'b0;
            err_illegal <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pkt_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
            end
        end else if (flush) begin
            // Flush also swallows same-cycle requests, so no error can be raised.
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (adm0) begin
                pkt_q[wr_ptr] <= '{op: i0_op, rd: i0_rd};
                a_q[wr_ptr]   <= i0_a;
                b_q[wr_ptr]   <= i0_b;
            end
            if (adm1) begin
                pkt_q[wr_ptr_next] <= '{op: i1_op, rd: i1_rd};
                a_q[wr_ptr_next]   <= i1_a;
                b_q[wr_ptr_next]   <= i1_b;
            end
            wr_ptr      <= wr_ptr + PW'(n_adm);
            rd_ptr      <= rd_ptr + PW'(deq);
            count_q     <= count_q + n_adm - CW'(deq);
            err_ovf     <= err_ovf | ovf_hit;
            err_illegal <= err_illegal | illegal_hit;
        end
    end

endmodule

// File: tb/tb_posu_req_queue.sv
// Self-checking bench for posu_req_queue: a reference queue model tracks
// admitted entries and every head/flag observation is compared against it.
module tb_posu_req_queue;
    import veer_types::*;

    localparam int DEPTH = 4;
    localparam int NBITS = 32;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0001;

    typedef struct {
        logic [3:0]       op;
        logic [4:0]       rd;
        logic [NBITS-1:0] a;
        logic [NBITS-1:0] b;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             i0_valid = 1'b0;
    posu_op_t         i0_op = '0;
    logic [4:0]       i0_rd = '0;
    logic [NBITS-1:0] i0_a = '0;
    logic [NBITS-1:0] i0_b = '0;
    logic             i1_valid = 1'b0;
    posu_op_t         i1_op = '0;
    logic [4:0]       i1_rd = '0;
    logic [NBITS-1:0] i1_a = '0;
    logic [NBITS-1:0] i1_b = '0;
    logic [2:0]       free_cnt;
    logic             out_valid;
    posu_op_t         out_op;
    logic [4:0]       out_rd;
    logic [NBITS-1:0] out_a;
    logic [NBITS-1:0] out_b;
    logic             out_ready = 1'b0;
    logic             err_ovf;
    logic             err_illegal;

    ent_t sb[$];
    logic exp_ovf;
    logic exp_ill;
    int   errors = 0;
    int   checks = 0;

    posu_req_queue #(.DEPTH(DEPTH), .NBITS(NBITS)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i0_valid(i0_valid), .i0_op(i0_op), .i0_rd(i0_rd), .i0_a(i0_a), .i0_b(i0_b),
        .i1_valid(i1_valid), .i1_op(i1_op), .i1_rd(i1_rd), .i1_a(i1_a), .i1_b(i1_b),
        .free_cnt(free_cnt), .out_valid(out_valid), .out_op(out_op), .out_rd(out_rd),
        .out_a(out_a), .out_b(out_b), .out_ready(out_ready),
        .err_ovf(err_ovf), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [3:0] op);
        return $countones(op) == 1;
    endfunction

    // Drives one cycle of requests and updates the reference model to match.
    task automatic drive(input logic v0, input logic [3:0] op0, input logic [4:0] rd0,
                         input logic [NBITS-1:0] a0, input logic [NBITS-1:0] b0,
                         input logic v1, input logic [3:0] op1, input logic [4:0] rd1,
                         input logic [NBITS-1:0] a1, input logic [NBITS-1:0] b1,
                         input logic rdy, input logic fl);
        int   space;
        logic deq;
        i0_valid = v0; i0_op = posu_op_t'(op0); i0_rd = rd0; i0_a = a0; i0_b = b0;
        i1_valid = v1; i1_op = posu_op_t'(op1); i1_rd = rd1; i1_a = a1; i1_b = b1;
        out_ready = rdy;
        flush = fl;
        deq = (sb.size() > 0) && rdy;
        space = DEPTH - sb.size() + int'(deq);
        if (deq) void'(sb.pop_front());
        if (fl) begin
            sb.delete();
        end else begin
            if (v0 && !legal(op0)) exp_ill = 1'b1;
            if (v1 && !legal(op1)) exp_ill = 1'b1;
            if (v0 && legal(op0)) begin
                if (space > 0) begin
                    sb.push_back('{op: op0, rd: rd0, a: a0, b: b0});
                    space--;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (v1 && legal(op1)) begin
                if (space > 0) sb.push_back('{op: op1, rd: rd1, a: a1, b: b1});
                else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        exp_ill = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if ({out_valid, free_cnt, err_ovf, err_illegal} !== {1'b0, 3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid/free/ovf/ill=%b/%0d/%b/%b required 0/4/0/0",
                     out_valid, free_cnt, err_ovf, err_illegal);
        end
        checks++;
        if ({out_op, out_rd, out_a, out_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_head: got op=%b rd=%0d a=%h b=%h required all zero",
                     out_op, out_rd, out_a, out_b);
        end
        drive(1, OP_ADD, 5'd3, 32'h11, 32'h22, 0, 4'b0, 5'd0, '0, '0, 0, 0);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_async_valid: got %b required 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, free_cnt} !== {1'b0, 3'd4}) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid=%b free=%0d required 0/4", out_valid, free_cnt);
        end
        do_reset();
    endtask

    task automatic test_fill_overflow();
        do_reset();
        drive(1, OP_ADD, 5'd1, 32'hA1, 32'hB1, 1, OP_MUL, 5'd2, 32'hA2, 32'hB2, 0, 0);
        tick();
        drive(1, OP_SUB, 5'd3, 32'hA3, 32'hB3, 1, OP_DIV, 5'd4, 32'hA4, 32'hB4, 0, 0);
        tick();
        checks++;
        if ({free_cnt, err_ovf} !== {3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fill_full: got free=%0d ovf=%b required 0/0", free_cnt, err_ovf);
        end
        drive(1, OP_ADD, 5'd5, 32'hA5, 32'hB5, 1, OP_SUB, 5'd6, 32'hA6, 32'hB6, 0, 0);
        tick();
        checks++;
        if ({err_ovf, free_cnt} !== {exp_ovf, 3'(DEPTH - sb.size())}) begin
            errors++;
            $display("[TB] FAIL fill_ovf: got ovf=%b free=%0d required %b/%0d",
                     err_ovf, free_cnt, exp_ovf, DEPTH - sb.size());
        end
        checks++;
        if ({out_op, out_rd} !== {OP_ADD, 5'd1}) begin
            errors++;
            $display("[TB] FAIL fill_head: got op=%b rd=%0d required 1000/1", out_op, out_rd);
        end
    endtask

    // Continues from the full queue left by test_fill_overflow.
    task automatic test_full_deq();
        drive(1, OP_MUL, 5'd9, 32'hC9, 32'hD9, 1, OP_ADD, 5'd10, 32'hCA, 32'hDA, 1, 0);
        tick();
        checks++;
        if ({free_cnt, err_ovf} !== {3'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL full_deq: got free=%0d ovf=%b required 0/1", free_cnt, err_ovf);
        end
        for (int n = 0; n < 8 && sb.size() > 0; n++) begin
            checks++;
            if (!out_valid || {out_op, out_rd, out_a, out_b} !== {sb[0].op, sb[0].rd, sb[0].a, sb[0].b}) begin
                errors++;
                $display("[TB] FAIL full_drain: got v=%b op=%b rd=%0d a=%h required op=%b rd=%0d a=%h",
                         out_valid, out_op, out_rd, out_a, sb[0].op, sb[0].rd, sb[0].a);
            end
            drive(0, 4'b0, 5'd0, '0, '0, 0, 4'b0, 5'd0, '0, '0, 1, 0);
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL full_empty: got valid=%b left=%0d required 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_i1_only();
        do_reset();
        drive(0, 4'b0, 5'd0, '0, '0, 1, OP_DIV, 5'd7, 32'h40000000, 32'h12345678, 0, 0);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_bypass: got valid=%b required 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out_op, out_rd, out_a, out_b} !== {1'b1, sb[0].op, sb[0].rd, sb[0].a, sb[0].b}) begin
            errors++;
            $display("[TB] FAIL i1_only: got v=%b op=%b rd=%0d a=%h b=%h required 1/%b/%0d/%h/%h",
                     out_valid, out_op, out_rd, out_a, out_b, sb[0].op, sb[0].rd, sb[0].a, sb[0].b);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1, 4'b0011, 5'd3, 32'h3, 32'h3, 1, OP_SUB, 5'd4, 32'h44, 32'h55, 0, 0);
        tick();
        checks++;
        if ({err_illegal, err_ovf, free_cnt} !== {exp_ill, 1'b0, 3'd3}) begin
            errors++;
            $display("[TB] FAIL illegal_flags: got ill=%b ovf=%b free=%0d required 1/0/3",
                     err_illegal, err_ovf, free_cnt);
        end
        checks++;
        if ({out_op, out_rd} !== {OP_SUB, 5'd4}) begin
            errors++;
            $display("[TB] FAIL illegal_head: got op=%b rd=%0d required 0100/4", out_op, out_rd);
        end
    endtask

    task automatic test_flush_wrap();
        logic [NBITS-1:0] ra;
        do_reset();
        drive(1, OP_ADD, 5'd1, 32'h1, 32'h1, 1, OP_MUL, 5'd2, 32'h2, 32'h2, 0, 0);
        tick();
        drive(1, OP_SUB, 5'd3, 32'h3, 32'h3, 0, 4'b0, 5'd0, '0, '0, 0, 0);
        tick();
        drive(1, OP_DIV, 5'd8, 32'h8, 32'h8, 1, 4'b0110, 5'd9, 32'h9, 32'h9, 1, 1);
        tick();
        checks++;
        if ({out_valid, free_cnt, err_ovf, err_illegal} !== {1'b0, 3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL flush: got valid/free/ovf/ill=%b/%0d/%b/%b required 0/4/0/0",
                     out_valid, free_cnt, err_ovf, err_illegal);
        end
        for (int k = 0; k < 5; k++) begin
            ra = $urandom;
            drive(1, OP_MUL, 5'(k + 11), ra, ~ra, 0, 4'b0, 5'd0, '0, '0, 1, 0);
            tick();
            checks++;
            if (!out_valid || {out_op, out_rd, out_a, out_b} !== {sb[0].op, sb[0].rd, sb[0].a, sb[0].b}) begin
                errors++;
                $display("[TB] FAIL wrap_head: got v=%b rd=%0d a=%h required rd=%0d a=%h",
                         out_valid, out_rd, out_a, sb[0].rd, sb[0].a);
            end
        end
        drive(0, 4'b0, 5'd0, '0, '0, 0, 4'b0, 5'd0, '0, '0, 1, 0);
        tick();
        checks++;
        if ({out_valid, free_cnt} !== {1'b0, 3'd4}) begin
            errors++;
            $display("[TB] FAIL wrap_empty: got valid=%b free=%0d required 0/4", out_valid, free_cnt);
        end
    endtask

    initial begin
        exp_ovf = 1'b0;
        exp_ill = 1'b0;
        test_reset();
        test_fill_overflow();
        test_full_deq();
        test_i1_only();
        test_illegal();
        test_flush_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running at 100000 required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/posu_req_queue.md
# posu_req_queue

Parametrised request buffer between decode and the posit execution unit (POSU). Accepts up to two posit operations per cycle from pipes i0 and i1, in program order, and holds up to DEPTH entries. Issues one entry per cycle to the POSU datapath over a valid/ready handshake. Replaces the single-slot, fixed-width posit packet path with configurable depth, operand width and error reporting.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- NBITS, 32: posit operand width.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held and same-cycle incoming requests.
- i0_valid  in  1  i0 request present.
- i0_op  in  posu_op_t  one-hot {add, sub, mul, div}.
- i0_rd  in  5  destination register.
- i0_a, i0_b  in  NBITS  operands.
- i1_valid, i1_op, i1_rd, i1_a, i1_b  in  as i0  second request, younger than i0.
- free_cnt  out  $clog2(DEPTH+1)  free entries, registered state.
- out_valid  out  1  head entry valid.
- out_op  out  posu_op_t  head opcode.
- out_rd  out  5  head destination.
- out_a, out_b  out  NBITS  head operands.
- out_ready  in  1  POSU accepts head.
- err_ovf  out  1  sticky: a request was dropped for lack of space.
- err_illegal  out  1  sticky: a valid request carried a non-one-hot opcode.

## Operation
- Storage: DEPTH-entry circular array; rd_ptr, wr_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count_q of $clog2(DEPTH+1) bits.
- Legal request: valid with exactly one opcode bit set. Illegal requests are dropped and set err_illegal; they take no slot.
- deq = out_valid & out_ready.
- space = DEPTH − count_q + deq. Legal requests are admitted oldest-first (i0 before i1) while space lasts. Each legal request not admitted sets err_ovf and is dropped; a dropped i0 never causes i1 to be dropped instead.
- Admitted entries write at wr_ptr, then wr_ptr+1, in order. Only i1 legal: i1 writes at wr_ptr.
- count_d = count_q + n_adm − deq; ptrs advance by n_adm and deq.
- out_* driven directly from array[rd_ptr]; out_valid = (count_q != 0).
- flush: count, rd_ptr and wr_ptr clear. Same-cycle requests are discarded and raise no errors. A same-cycle deq still completes on the interface but has no further effect.
- err_ovf and err_illegal clear only on rst.
- free_cnt = DEPTH − count_q.

## Timing
- Reset values: out_valid 0, free_cnt DEPTH, err_ovf 0, err_illegal 0, pointers 0. out_op, out_rd, out_a and out_b are 0 (array cleared on reset).
- Enqueue in cycle N: visible at head no earlier than N+1. No same-cycle bypass.
- Dequeue: zero-latency combinational view of head; pointer advances at the clock edge when deq.
- Full (count_q = DEPTH) with deq: one new request is admitted the same cycle; count stays DEPTH.
- Empty with two legal requests: both admitted; out_valid is 1 at N+1 and shows the i0 entry.
- Error flags rise one cycle after the offending request.
- out_valid must not depend on out_ready.
- Combinational path out_ready → admission is permitted.
- rst asserted mid-operation: all state clears immediately, asynchronously.

## Structure
- The veer_types package carries:
  - posu_op_t: packed struct {add, sub, mul, div}.
  - posu_req_pkt_t: packed struct {posu_op_t op; logic [4:0] rd}.
  - Operand width is carried separately as the NBITS parameter.
- One sub-module: posu_onehot_chk, a combinational legality check on a posu_op_t.
- The queue body is a single module with no further hierarchy.

## Test plan
- Reset, then idle → out_valid 0, free_cnt 4, both error flags 0.
- Both pipes legal each cycle (add rd1, then mul rd2, …), out_ready 0 → after 2 cycles free_cnt 0. A third cycle sets err_ovf; out shows add rd1.
- Full queue, out_ready 1, i0 and i1 legal → i0 admitted, i1 dropped, err_ovf 1. Drain yields the original 4 entries in order, then the i0 entry.
- Only i1 valid with op div, rd 7, a=0x40000000 → next cycle out_op div, out_rd 7, out_a 0x40000000.
- i0_op = 4'b0011 valid, i1 legal sub → only sub queued, err_illegal 1, free_cnt 3.
- Queue holds 3 entries, flush together with both pipes valid → next cycle out_valid 0, free_cnt 4, no error flag set. Then 5 sequential single enqueues with wrap-around drain in order.
